// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: debounced start/lap buttons driving a BCD SS.hh stopwatch with a sticky minute flag.
// The lap state and display freeze are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap_core #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SEC_WRAP        = 60
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       tick_100,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic [3:0] sec_0_01,
   output logic [3:0] sec_0_1,
   output logic [3:0] sec_1,
   output logic [3:0] sec_10,
   output logic       min,
   output logic       running
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] WRAP_T = 4'((SEC_WRAP - 1) / 10);
   localparam logic [3:0] WRAP_U = 4'((SEC_WRAP - 1) % 10);

   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

   logic [1:0] w_raw, w_press;
   assign w_raw = {btn_lap, btn_start};

   for (genvar g = 0; g < 2; g++) begin : g_db
      logic r_s1, r_s2, r_db, r_db_d, r_press;
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk_50M or posedge rst) begin
         if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_s1 <= w_raw[g];
            r_s2 <= r_s1;
            if (r_s2 == r_db) r_cnt <= '0;
            else if (r_cnt == CMAX) begin
               r_cnt <= '0;
               r_db  <= r_s2;
            end else r_cnt <= r_cnt + 1'b1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
         end
      end
      assign w_press[g] = r_press;
   end

   state_t r_st, w_nxt;
   logic [3:0] r_d0, r_d1, r_d2, r_d3;
   logic [15:0] r_disp, w_live;
   logic r_min, r_running, w_clr, w_hold, w_cnt_en;
   logic w_c0, w_c1, w_c2, w_wrap;
   logic w_s, w_l;

   assign w_s = w_press[0];
   assign w_l = w_press[1] & ~w_press[0];

   always_comb begin
      w_nxt = r_st;
      w_clr = 1'b0;
      case (r_st)
         IDLE: w_nxt = w_s ? RUN : IDLE;
`ifdef STOPWATCH_LAP_EN
         RUN:  w_nxt = w_s ? STOP : w_l ? LAP : RUN;
         LAP:  w_nxt = w_s ? STOP : w_l ? RUN : LAP;
`else
         RUN:  w_nxt = w_s ? STOP : RUN;
`endif
         STOP: begin
            w_nxt = w_s ? RUN : w_l ? IDLE : STOP;
            w_clr = w_l;
         end
         default: w_nxt = IDLE;
      endcase
   end

`ifdef STOPWATCH_LAP_EN
   // Entering LAP loads the live count once; staying in LAP holds it.
   assign w_hold = (r_st == LAP) && (w_nxt == LAP);
`else
   assign w_hold = 1'b0;
`endif

   assign w_cnt_en = tick_100 && ((r_st == RUN) || (r_st == LAP));
   assign w_c0   = r_d0 == 4'd9;
   assign w_c1   = w_c0 && (r_d1 == 4'd9);
   assign w_c2   = w_c1 && (r_d2 == 4'd9);
   assign w_wrap = w_c1 && (r_d3 == WRAP_T) && (r_d2 == WRAP_U);
   assign w_live = {r_d3, r_d2, r_d1, r_d0};

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         r_st      <= IDLE;
         r_running <= 1'b0;
         r_min     <= 1'b0;
         r_d0      <= '0;
         r_d1      <= '0;
         r_d2      <= '0;
         r_d3      <= '0;
         r_disp    <= '0;
      end else begin
         r_st      <= w_nxt;
         r_running <= (w_nxt == RUN) || (w_nxt == LAP);
         r_disp    <= w_hold ? r_disp : w_live;
         if (w_clr) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
            r_min <= 1'b0;
         end else if (w_cnt_en) begin
            r_d0  <= w_c0 ? 4'd0 : r_d0 + 4'd1;
            r_d1  <= w_c1 ? 4'd0 : w_c0 ? r_d1 + 4'd1 : r_d1;
            r_d2  <= (w_wrap || w_c2) ? 4'd0 : w_c1 ? r_d2 + 4'd1 : r_d2;
            r_d3  <= w_wrap ? 4'd0 : w_c2 ? r_d3 + 4'd1 : r_d3;
            r_min <= r_min | w_wrap;
         end
      end
   end

   assign {sec_10, sec_1, sec_0_1, sec_0_01} = r_disp;
   assign min     = r_min;
   assign running = r_running;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// tb_stopwatch_lap_core: directed checks of debounce, FSM, BCD counting, wrap and lap hold.
// Lap-hold expectations follow whether STOPWATCH_LAP_EN is defined for the build.
module tb_stopwatch_lap_core;
   logic clk_50M = 1'b0;
   logic rst = 1'b1;
   logic tick_100 = 1'b0;
   logic btn_start = 1'b0;
   logic btn_lap = 1'b0;
   logic [3:0] sec_0_01, sec_0_1, sec_1, sec_10;
   logic min, running;
   logic [15:0] disp;
   int n_tests = 0;
   int n_fail = 0;

   stopwatch_lap_core #(.DEBOUNCE_CYCLES(4), .SEC_WRAP(60)) dut (
      .clk_50M(clk_50M), .rst(rst), .tick_100(tick_100),
      .btn_start(btn_start), .btn_lap(btn_lap),
      .sec_0_01(sec_0_01), .sec_0_1(sec_0_1), .sec_1(sec_1), .sec_10(sec_10),
      .min(min), .running(running)
   );

   always #5 clk_50M = ~clk_50M;
   assign disp = {sec_10, sec_1, sec_0_1, sec_0_01};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick_100 = 1'b1;
         cyc(1);
         tick_100 = 1'b0;
         cyc(9);
      end
   endtask

   task automatic press(input logic s, input logic l, input int hold);
      btn_start = s;
      btn_lap   = l;
      cyc(hold);
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      cyc(12);
   endtask

   initial begin
      cyc(3);
      chk("rst_disp", disp, 16'h0000);
      chk("rst_min", min, 1'b0);
      chk("rst_run", running, 1'b0);
      rst = 1'b0;
      cyc(2);
      // reset mid-run at 12.34
      press(1, 0, 8);
      chk("t1_run", running, 1'b1);
      ticks(1234);
      chk("t1_1234", disp, 16'h1234);
      rst = 1'b1;
      #1;
      chk("t1_rst_disp", disp, 16'h0000);
      chk("t1_rst_run", running, 1'b0);
      cyc(2);
      rst = 1'b0;
      cyc(2);
      ticks(5);
      chk("t1_idle_nocount", disp, 16'h0000);
      // run, stop, hold
      press(1, 0, 8);
      ticks(150);
      chk("t2_0150", disp, 16'h0150);
      chk("t2_run", running, 1'b1);
      press(1, 0, 8);
      chk("t2_stop", running, 1'b0);
      ticks(20);
      chk("t2_held", disp, 16'h0150);
      // clear, then wrap from 59.98
      press(0, 1, 8);
      chk("t3_clr_disp", disp, 16'h0000);
      chk("t3_clr_run", running, 1'b0);
      press(1, 0, 8);
      ticks(5998);
      chk("t3_5998", disp, 16'h5998);
      ticks(1);
      chk("t3_5999", disp, 16'h5999);
      chk("t3_min0", min, 1'b0);
      ticks(1);
      chk("t3_wrap", disp, 16'h0000);
      chk("t3_min1", min, 1'b1);
      ticks(3);
      chk("t3_after", disp, 16'h0003);
      press(1, 0, 8);
      press(0, 1, 8);
      chk("t3_clr2_disp", disp, 16'h0000);
      chk("t3_clr2_min", min, 1'b0);
      chk("t3_clr2_run", running, 1'b0);
      // lap hold
      press(1, 0, 8);
      ticks(300);
      chk("t4_0300", disp, 16'h0300);
      press(0, 1, 8);
      ticks(50);
`ifdef STOPWATCH_LAP_EN
      chk("t4_frozen", disp, 16'h0300);
`else
      chk("t4_live", disp, 16'h0350);
`endif
      chk("t4_run", running, 1'b1);
      press(0, 1, 8);
      chk("t4_release", disp, 16'h0350);
      ticks(1);
      chk("t4_0351", disp, 16'h0351);
      // simultaneous start and lap in RUN
      press(1, 1, 8);
      chk("t6_stop", running, 1'b0);
      ticks(2);
      chk("t6_nocount", disp, 16'h0351);
      press(1, 0, 8);
      chk("t6_resume", running, 1'b1);
      ticks(1);
      chk("t6_0352", disp, 16'h0352);
      // glitch rejected, minimal press accepted once
      press(1, 0, 2);
      chk("t5_glitch", running, 1'b1);
      ticks(1);
      chk("t5_glitch_cnt", disp, 16'h0353);
      press(1, 0, 4);
      chk("t5_press4", running, 1'b0);
      ticks(1);
      chk("t5_press4_cnt", disp, 16'h0353);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
